// File: rtl/strv32i_pkg.sv
// Shared STRV32I definitions: funct3 codes, LSU state, error causes and the latched request.
package strv32i_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned LANES = XLEN / 8;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } lsu_state_t;

   localparam logic [1:0] CAUSE_NONE       = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL    = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

   typedef struct packed {
      logic       we;
      logic [2:0] funct3;
      logic [1:0] offset;
   } lsu_req_t;

   // Legal width/sign codes differ between loads and stores.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Read-path lane select: shift the bus word down to the addressed byte, then extend.
module lsu_load_align
   import strv32i_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      data    = shifted;
      case (funct3)
         F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  data = {24'h000000, shifted[7:0]};
         F3_LHU:  data = {16'h0000, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: single-outstanding req/ack bus, lane masks, load extension,
// pipeline stall and misaligned / illegal / timeout reporting.
module load_store_unit
   import strv32i_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            mem_req_in,
   input  logic            mem_we_in,
   input  logic [2:0]      funct3_in,
   input  logic [XLEN-1:0] addr_in,
   input  logic [XLEN-1:0] rs2_in,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [LANES-1:0] dmem_wmask_o,
   input  logic            dmem_ack_in,
   input  logic [XLEN-1:0] dmem_rdata_in,
   output logic [XLEN-1:0] load_output_o,
   output logic            stall_o,
   output logic            done_o,
   output logic            misaligned_o,
   output logic            access_fault_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t      state;
   lsu_req_t        req_q;
   logic [CNT_W-1:0] wait_cnt;

   logic             legal;
   logic             misaligned;
   logic [1:0]       req_cause;
   logic [1:0]       pulse_cause;
   logic             expired;
   logic [XLEN-1:0]  st_wdata;
   logic [LANES-1:0] st_mask;
   logic [XLEN-1:0]  aligned_load;

   // Request decode: legality first, alignment only matters for legal codes.
   always_comb begin
      legal      = f3_legal(mem_we_in, funct3_in);
      misaligned = 1'b0;
      if (funct3_in[1:0] == 2'b01) misaligned = addr_in[0];
      if (funct3_in[1:0] == 2'b10) misaligned = (addr_in[1:0] != 2'b00);
      req_cause = CAUSE_NONE;
      if (!legal)         req_cause = CAUSE_ILLEGAL;
      else if (misaligned) req_cause = CAUSE_MISALIGNED;
   end

   // Store lane replication and byte mask; loads never write.
   always_comb begin
      st_wdata = rs2_in;
      st_mask  = '0;
      if (mem_we_in) begin
         case (funct3_in)
            F3_SB: begin
               st_wdata = {4{rs2_in[7:0]}};
               st_mask  = 4'b0001 << addr_in[1:0];
            end
            F3_SH: begin
               st_wdata = {2{rs2_in[15:0]}};
               st_mask  = 4'b0011 << addr_in[1:0];
            end
            default: begin
               st_wdata = rs2_in;
               st_mask  = 4'b1111;
            end
         endcase
      end
   end

   always_comb begin
      expired     = (wait_cnt == CNT_LAST);
      pulse_cause = CAUSE_NONE;
      if (state == IDLE && mem_req_in)
         pulse_cause = req_cause;
      else if (state == BUSY && !dmem_ack_in && expired)
         pulse_cause = CAUSE_TIMEOUT;
   end

   assign stall_o = (state == BUSY) ||
                    ((state == IDLE) && mem_req_in && (req_cause == CAUSE_NONE));

   lsu_load_align u_align (
      .rdata  (dmem_rdata_in),
      .funct3 (req_q.funct3),
      .offset (req_q.offset),
      .data   (aligned_load)
   );

   // Main FSM with registered bus and status outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         req_q          <= '0;
         wait_cnt       <= '0;
         dmem_req_o     <= 1'b0;
         dmem_we_o      <= 1'b0;
         dmem_addr_o    <= '0;
         dmem_wdata_o   <= '0;
         dmem_wmask_o   <= '0;
         load_output_o  <= '0;
         done_o         <= 1'b0;
         misaligned_o   <= 1'b0;
         access_fault_o <= 1'b0;
      end else begin
         done_o         <= 1'b0;
         misaligned_o   <= (pulse_cause == CAUSE_MISALIGNED);
         access_fault_o <= (pulse_cause == CAUSE_ILLEGAL) || (pulse_cause == CAUSE_TIMEOUT);
         case (state)
            IDLE: begin
               if (mem_req_in && req_cause == CAUSE_NONE) begin
                  state        <= BUSY;
                  req_q        <= '{we: mem_we_in, funct3: funct3_in, offset: addr_in[1:0]};
                  wait_cnt     <= '0;
                  dmem_req_o   <= 1'b1;
                  dmem_we_o    <= mem_we_in;
                  dmem_addr_o  <= {addr_in[XLEN-1:2], 2'b00};
                  dmem_wdata_o <= st_wdata;
                  dmem_wmask_o <= st_mask;
               end
            end
            BUSY: begin
               // Ack takes priority over an expiring wait counter.
               if (dmem_ack_in) begin
                  if (!req_q.we) load_output_o <= aligned_load;
                  done_o     <= 1'b1;
                  dmem_req_o <= 1'b0;
                  state      <= IDLE;
               end else if (expired) begin
                  dmem_req_o <= 1'b0;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus/response items,
// a monitor pops and compares them when the DUT presents a request or a completion pulse.
module tb_load_store_unit;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        mem_req_in;
   logic        mem_we_in;
   logic [2:0]  funct3_in;
   logic [31:0] addr_in;
   logic [31:0] rs2_in;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wmask_o;
   logic        dmem_ack_in;
   logic [31:0] dmem_rdata_in;
   logic [31:0] load_output_o;
   logic        stall_o;
   logic        done_o;
   logic        misaligned_o;
   logic        access_fault_o;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_req_in(mem_req_in), .mem_we_in(mem_we_in),
      .funct3_in(funct3_in), .addr_in(addr_in), .rs2_in(rs2_in),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
      .dmem_ack_in(dmem_ack_in), .dmem_rdata_in(dmem_rdata_in),
      .load_output_o(load_output_o), .stall_o(stall_o), .done_o(done_o),
      .misaligned_o(misaligned_o), .access_fault_o(access_fault_o)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } bus_t;

   typedef struct {
      logic [2:0]  flags;   // {done, misaligned, fault}
      logic        is_load;
      logic [31:0] data;
   } resp_t;

   bus_t  bus_q[$];
   resp_t resp_q[$];
   int    total = 0;
   int    bad   = 0;
   logic  prev_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: compare bus request on its rising edge and every completion/error pulse.
   always @(posedge clk_in) begin
      bus_t  b;
      resp_t r;
      #1;
      if (dmem_req_o && !prev_req) begin
         if (bus_q.size() == 0) check("bus_unexpected", 32'(dmem_req_o), 32'(0));
         else begin
            b = bus_q.pop_front();
            check("bus_we", 32'(dmem_we_o), 32'(b.we));
            check("bus_addr", dmem_addr_o, b.addr);
            check("bus_mask", 32'(dmem_wmask_o), 32'(b.mask));
            if (b.we) check("bus_wdata", dmem_wdata_o, b.wdata);
         end
      end
      prev_req = dmem_req_o;
      if (done_o || misaligned_o || access_fault_o) begin
         if (resp_q.size() == 0) check("resp_unexpected", 32'({done_o, misaligned_o, access_fault_o}), 32'(0));
         else begin
            r = resp_q.pop_front();
            check("resp_flags", 32'({done_o, misaligned_o, access_fault_o}), 32'(r.flags));
            if (r.is_load) check("load_output", load_output_o, r.data);
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk_in);
      mem_req_in = 1'b1; mem_we_in = we; funct3_in = f3; addr_in = a; rs2_in = d;
   endtask

   task automatic run_ok(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int waits,
                         input logic [31:0] rdata, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_mask, input logic [31:0] exp_load);
      bus_t  b;
      resp_t r;
      b = '{we: we, addr: {a[31:2], 2'b00}, wdata: exp_wdata, mask: exp_mask};
      r = '{flags: 3'b100, is_load: !we, data: exp_load};
      bus_q.push_back(b);
      resp_q.push_back(r);
      issue(we, f3, a, d);
      #1 check({name, "_stall_accept"}, 32'(stall_o), 32'(1));
      @(negedge clk_in);
      mem_req_in = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         check({name, "_req_wait"}, 32'(dmem_req_o), 32'(1));
         check({name, "_stall_wait"}, 32'(stall_o), 32'(1));
         if (i < waits) @(negedge clk_in);
      end
      dmem_ack_in = 1'b1; dmem_rdata_in = rdata;
      @(negedge clk_in);
      dmem_ack_in = 1'b0; dmem_rdata_in = 32'h0;
      check({name, "_done"}, 32'(done_o), 32'(1));
      check({name, "_stall_done"}, 32'(stall_o), 32'(0));
      check({name, "_req_done"}, 32'(dmem_req_o), 32'(0));
   endtask

   task automatic run_err(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic exp_mis, input logic exp_fault);
      resp_t r;
      r = '{flags: {1'b0, exp_mis, exp_fault}, is_load: 1'b0, data: 32'h0};
      resp_q.push_back(r);
      issue(we, f3, a, 32'h0);
      #1 check({name, "_stall"}, 32'(stall_o), 32'(0));
      @(negedge clk_in);
      mem_req_in = 1'b0;
      check({name, "_req"}, 32'(dmem_req_o), 32'(0));
      check({name, "_stall_after"}, 32'(stall_o), 32'(0));
      check({name, "_mis"}, 32'(misaligned_o), 32'(exp_mis));
      check({name, "_fault"}, 32'(access_fault_o), 32'(exp_fault));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_t  b;
      resp_t r;
      rst_n_in = 1'b0; mem_req_in = 1'b0; mem_we_in = 1'b0; funct3_in = 3'b000;
      addr_in = 32'h0; rs2_in = 32'h0; dmem_ack_in = 1'b0; dmem_rdata_in = 32'h0;
      repeat (2) @(negedge clk_in);
      check("rst_req", 32'(dmem_req_o), 32'(0));
      check("rst_stall", 32'(stall_o), 32'(0));
      check("rst_load", load_output_o, 32'h0);
      check("rst_flags", 32'({done_o, misaligned_o, access_fault_o, dmem_we_o}), 32'(0));
      check("rst_bus", dmem_addr_o | dmem_wdata_o | 32'(dmem_wmask_o), 32'h0);
      rst_n_in = 1'b1;

      run_ok("sw",   1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0);
      run_ok("lw",   1'b0, 3'b010, 32'h100, 32'h0,        1, 32'hDEADBEEF, 32'h0, 4'b0000, 32'hDEADBEEF);
      run_ok("lb3",  1'b0, 3'b000, 32'h103, 32'h0,        0, 32'h80FF7F01, 32'h0, 4'b0000, 32'hFFFFFF80);
      run_ok("lbu3", 1'b0, 3'b100, 32'h103, 32'h0,        0, 32'h80FF7F01, 32'h0, 4'b0000, 32'h00000080);
      run_ok("lb1",  1'b0, 3'b000, 32'h101, 32'h0,        0, 32'h80FF7F01, 32'h0, 4'b0000, 32'h0000007F);
      run_ok("lh2",  1'b0, 3'b001, 32'h102, 32'h0,        0, 32'h80FF7F01, 32'h0, 4'b0000, 32'hFFFF80FF);
      run_ok("lhu2", 1'b0, 3'b101, 32'h102, 32'h0,        1, 32'h80FF7F01, 32'h0, 4'b0000, 32'h000080FF);
      run_ok("lh0",  1'b0, 3'b001, 32'h100, 32'h0,        0, 32'h80FF7F01, 32'h0, 4'b0000, 32'h00007F01);
      run_ok("sh",   1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0, 32'hABCDABCD, 4'b1100, 32'h0);
      run_ok("sb",   1'b1, 3'b000, 32'h101, 32'h00000055, 1, 32'h0, 32'h55555555, 4'b0010, 32'h0);
      check("store_keeps_load", load_output_o, 32'h00007F01);

      run_err("lw_mis",  1'b0, 3'b010, 32'h102, 1'b1, 1'b0);
      run_err("lh_mis",  1'b0, 3'b001, 32'h101, 1'b1, 1'b0);
      run_err("ld_ill",  1'b0, 3'b011, 32'h100, 1'b0, 1'b1);
      run_err("st_ill",  1'b1, 3'b100, 32'h100, 1'b0, 1'b1);

      // Timeout: no ack for the full 4-cycle budget.
      b = '{we: 1'b0, addr: 32'h200, wdata: 32'h0, mask: 4'b0000};
      r = '{flags: 3'b001, is_load: 1'b0, data: 32'h0};
      bus_q.push_back(b);
      resp_q.push_back(r);
      issue(1'b0, 3'b010, 32'h200, 32'h0);
      @(negedge clk_in);
      mem_req_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_req_held", 32'(dmem_req_o), 32'(1));
         @(negedge clk_in);
      end
      check("to_req_drop", 32'(dmem_req_o), 32'(0));
      check("to_fault", 32'(access_fault_o), 32'(1));
      check("to_stall", 32'(stall_o), 32'(0));
      check("to_no_done", 32'(done_o), 32'(0));

      // Ack on the last allowed cycle completes normally.
      run_ok("ack4", 1'b1, 3'b010, 32'h204, 32'h11223344, 3, 32'h0, 32'h11223344, 4'b1111, 32'h0);
      check("ack4_no_fault", 32'(access_fault_o), 32'(0));

      // Reset during BUSY abandons the access asynchronously.
      b = '{we: 1'b0, addr: 32'h300, wdata: 32'h0, mask: 4'b0000};
      bus_q.push_back(b);
      issue(1'b0, 3'b010, 32'h300, 32'h0);
      @(negedge clk_in);
      mem_req_in = 1'b0;
      check("rm_req_before", 32'(dmem_req_o), 32'(1));
      rst_n_in = 1'b0;
      #1;
      check("rm_req", 32'(dmem_req_o), 32'(0));
      check("rm_stall", 32'(stall_o), 32'(0));
      check("rm_load", load_output_o, 32'h0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      run_ok("lw_after_rst", 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'hCAFEF00D, 32'h0, 4'b0000, 32'hCAFEF00D);

      repeat (3) @(negedge clk_in);
      check("bus_q_empty", 32'(bus_q.size()), 32'(0));
      check("resp_q_empty", 32'(resp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
